data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_resp_pkg.sv | 22 ++
 rtl/resp_word_ram.sv | 31 +++
 rtl/data_mem_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared constants for the data memory responder: FSM state encodings and
// default geometry/timing parameters.
package mem_resp_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Default number of 32-bit words and request-to-response latency
    localparam int DEFAULT_DEPTH   = 128;
    localparam int DEFAULT_LATENCY = 2;

    // Saturation value of the error counter
    localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

    // Word-address width for a given depth (at least one bit)
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/resp_word_ram.sv
// Word storage for the responder: one synchronous write port and one
// combinational read port. Contents survive reset; zero at simulation start.
module resp_word_ram
    import mem_resp_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

    // Write port: commit one word per enabled edge, never cleared by reset
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port: asynchronous lookup of the latched word index
    always_comb begin
        rdata_o = mem_q[raddr_i];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder. A request is accepted in IDLE, waits
// LATENCY cycles in WAIT/counter, then is presented in RESP until consumed.
// Stores commit at the accept edge; loads sample memory on WAIT->RESP.
// Handshake: a transfer happens on an edge where valid && ready are both 1;
// the responder holds resp_* stable while resp_valid_o=1 and resp_ready_i=0.
module data_mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH   = DEFAULT_DEPTH,
    parameter int LATENCY = DEFAULT_LATENCY
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [7:0]  err_count_o,
    output logic [1:0]  state_o
);

    localparam int         AW     = addr_width(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          lat_write_q, lat_write_d;
    logic          lat_err_q, lat_err_d;
    logic [AW-1:0] lat_idx_q, lat_idx_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic [7:0]    err_count_q, err_count_d;

    logic          req_err;
    logic          accept;
    logic          ram_we;
    logic [31:0]   ram_rdata;

    // Classify the presented request: misaligned or beyond the last word
    always_comb begin
        req_err = (req_addr_i[1:0] != 2'b00) ||
                  ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH));
        accept  = (state_q == ST_IDLE) && req_valid_i;
        // Reset wins over an accept on the same edge, so no write then either
        ram_we  = accept && req_write_i && !req_err && !rst_i;
    end

    // Next-state logic for FSM, latency counter, response and error count.
    // Store data goes straight to memory at accept, so only the word index,
    // direction and error flag need to be held for the response.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_write_d  = lat_write_q;
        lat_err_d    = lat_err_q;
        lat_idx_d    = lat_idx_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        err_count_d  = err_count_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    lat_write_d = req_write_i;
                    lat_err_d   = req_err;
                    lat_idx_d   = req_addr_i[AW+1:2];
                    cnt_d       = LAT_M1;
                    state_d     = ST_WAIT;
                    if (req_err && (err_count_q != ERR_COUNT_MAX)) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = lat_err_q;
                    resp_rdata_d = (lat_write_q || lat_err_q) ? 32'h0 : ram_rdata;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = 32'h0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            lat_write_q  <= 1'b0;
            lat_err_q    <= 1'b0;
            lat_idx_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            err_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lat_write_q  <= lat_write_d;
            lat_err_q    <= lat_err_d;
            lat_idx_q    <= lat_idx_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            err_count_q  <= err_count_d;
        end
    end

    resp_word_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (req_addr_i[AW+1:2]),
        .wdata_i (req_wdata_i),
        .raddr_i (lat_idx_q),
        .rdata_o (ram_rdata)
    );

    // Output mapping
    always_comb begin
        req_ready_o  = (state_q == ST_IDLE);
        resp_valid_o = resp_valid_q;
        resp_rdata_o = resp_rdata_q;
        resp_err_o   = resp_err_q;
        err_count_o  = err_count_q;
        state_o      = state_q;
    end

endmodule
